// File: rtl/rfg_axis_protocol_arbiter_pkg.sv
// Shared types and frame-format constants for the protocol-engine port arbiter.
package rfg_axis_arb_pkg;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_HEADER,
    ST_ADDR,
    ST_LENA,
    ST_LENB,
    ST_PAYLOAD
  } arb_state_e;

  localparam int unsigned WRITE_BIT = 0;
  localparam int unsigned READ_BIT  = 1;
  localparam int unsigned INCR_BIT  = 2;
  localparam int unsigned VCH_LSB   = 4;

  localparam int unsigned OFS_HEADER  = 0;
  localparam int unsigned OFS_ADDR    = 1;
  localparam int unsigned OFS_LEN_LSB = 2;
  localparam int unsigned OFS_LEN_MSB = 3;
  localparam int unsigned OFS_PAYLOAD = 4;

  // A header with neither read nor write set is a one-byte frame.
  function automatic logic hdr_is_noop(input logic [7:0] hdr);
    return !(hdr[WRITE_BIT] | hdr[READ_BIT]);
  endfunction

endpackage

// File: rtl/rfg_axis_rr_arbiter.sv
// Round-robin request picker: combinational grant from the pointer, pointer advances past the releasing port.
module rfg_axis_rr_arbiter
  import rfg_axis_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  input  logic [IDX_W-1:0]     adv_from,
  output logic                 any_req,
  output logic [NUM_PORTS-1:0] gnt_oh,
  output logic [IDX_W-1:0]     gnt_idx
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] idx;

  always_comb begin
    any_req = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = IDX_W'((32'(rr_ptr_q) + i) % NUM_PORTS);
      if (!any_req && req[idx]) begin
        any_req     = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = (32'(adv_from) == NUM_PORTS - 1) ? '0 : adv_from + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/rfg_axis_protocol_arbiter.sv
// Frame-granular round-robin share of the protocol engine's byte stream, plus tdest-routed readback demux.
module rfg_axis_protocol_arbiter
  import rfg_axis_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  input  logic [DATA_WIDTH-1:0]           rb_s_axis_tdata,
  input  logic                            rb_s_axis_tvalid,
  output logic                            rb_s_axis_tready,
  input  logic                            rb_s_axis_tlast,
  input  logic [7:0]                      rb_s_axis_tdest,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rb_m_axis_tdata,
  output logic [NUM_PORTS-1:0]            rb_m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            rb_m_axis_tready,
  output logic [NUM_PORTS-1:0]            rb_m_axis_tlast,
  output logic                            grant_active
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [NUM_PORTS-1:0]   gnt_oh_q, gnt_oh_d;
  logic                   wr_q, wr_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [15:0]            count_q, count_d;
  logic                   grant_active_q;

  logic                   any_req, release_frame, busy, accept;
  logic [NUM_PORTS-1:0]   arb_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic [DATA_WIDTH-1:0]  sel_byte;
  logic [IDX_W-1:0]       rb_dest_idx;

  rfg_axis_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .clk      (aclk),
    .rst_n    (aresetn),
    .req      (s_axis_tvalid),
    .advance  (release_frame),
    .adv_from (grant_q),
    .any_req  (any_req),
    .gnt_oh   (arb_oh),
    .gnt_idx  (arb_idx)
  );

  assign busy          = (state_q != ST_ARB);
  assign sel_byte      = s_axis_tdata[DATA_WIDTH*grant_q +: DATA_WIDTH];
  assign accept        = busy && s_axis_tvalid[grant_q] && m_axis_tready;
  assign m_axis_tdata  = sel_byte;
  assign m_axis_tvalid = busy && s_axis_tvalid[grant_q];
  assign m_axis_tid    = ID_WIDTH'(grant_q);
  assign s_axis_tready = busy ? (gnt_oh_q & {NUM_PORTS{m_axis_tready}}) : '0;
  assign grant_active  = grant_active_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gnt_oh_d      = gnt_oh_q;
    wr_d          = wr_q;
    len_lo_d      = len_lo_q;
    count_d       = count_q;
    release_frame = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (any_req) begin
          grant_d  = arb_idx;
          gnt_oh_d = arb_oh;
          state_d  = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (accept) begin
          if (hdr_is_noop(sel_byte)) begin
            release_frame = 1'b1;
          end else begin
            wr_d    = sel_byte[WRITE_BIT];
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: if (accept) state_d = ST_LENA;
      ST_LENA: begin
        if (accept) begin
          len_lo_d = sel_byte;
          state_d  = ST_LENB;
        end
      end
      ST_LENB: begin
        if (accept) begin
          // 16-bit count: a zero length runs the full 65536 bytes before count hits 1.
          if (wr_q) begin
            count_d = {sel_byte, len_lo_q};
            state_d = ST_PAYLOAD;
          end else begin
            release_frame = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          count_d = count_q - 16'd1;
          if (count_q == 16'd1) release_frame = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (release_frame) state_d = ST_ARB;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= ST_ARB;
      grant_q        <= '0;
      gnt_oh_q       <= '0;
      wr_q           <= 1'b0;
      len_lo_q       <= '0;
      count_q        <= '0;
      grant_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      gnt_oh_q       <= gnt_oh_d;
      wr_q           <= wr_d;
      len_lo_q       <= len_lo_d;
      count_q        <= count_d;
      grant_active_q <= (state_d != ST_ARB);
    end
  end

  assign rb_dest_idx     = rb_s_axis_tdest[IDX_W-1:0];
  assign rb_m_axis_tdata = {NUM_PORTS{rb_s_axis_tdata}};

  always_comb begin
    rb_m_axis_tvalid = '0;
    rb_m_axis_tlast  = '0;
    rb_s_axis_tready = 1'b1;
    if (32'(rb_s_axis_tdest) < NUM_PORTS) begin
      rb_m_axis_tvalid[rb_dest_idx] = rb_s_axis_tvalid;
      rb_m_axis_tlast[rb_dest_idx]  = rb_s_axis_tlast;
      rb_s_axis_tready              = rb_m_axis_tready[rb_dest_idx];
    end
  end

endmodule

// File: tb/tb_rfg_axis_protocol_arbiter.sv
// Bench for rfg_axis_protocol_arbiter: frame-level reference model compared every cycle, plus literal pins.
module tb_rfg_axis_protocol_arbiter;

  localparam int N = 4;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [N*8-1:0] s_tdata = '0;
  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tready;
  logic [7:0]     m_tdata;
  logic           m_tvalid;
  logic           m_tready = 1'b0;
  logic [7:0]     m_tid;
  logic [7:0]     rb_tdata = '0;
  logic           rb_tvalid = 1'b0;
  logic           rb_tready;
  logic           rb_tlast = 1'b0;
  logic [7:0]     rb_tdest = '0;
  logic [N*8-1:0] rb_m_tdata;
  logic [N-1:0]   rb_m_tvalid;
  logic [N-1:0]   rb_m_tready = '0;
  logic [N-1:0]   rb_m_tlast;
  logic           grant_active;

  rfg_axis_protocol_arbiter #(
    .NUM_PORTS  (N),
    .DATA_WIDTH (8),
    .ID_WIDTH   (8)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_tdata     (s_tdata),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tid       (m_tid),
    .rb_s_axis_tdata  (rb_tdata),
    .rb_s_axis_tvalid (rb_tvalid),
    .rb_s_axis_tready (rb_tready),
    .rb_s_axis_tlast  (rb_tlast),
    .rb_s_axis_tdest  (rb_tdest),
    .rb_m_axis_tdata  (rb_m_tdata),
    .rb_m_axis_tvalid (rb_m_tvalid),
    .rb_m_axis_tready (rb_m_tready),
    .rb_m_axis_tlast  (rb_m_tlast),
    .grant_active     (grant_active)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Driver queues (what each port still has to send) and the model's own copy.
  byte unsigned drv_q [N][$];
  byte unsigned mdl_q [N][$];
  int           flen_q[N][$];
  int           cur = -1;
  int           rr = 0;
  int           remaining = 0;
  int           cyc = 0;
  int           acc_tid[$];
  int           acc_cyc[$];
  int           valid_pct = 100;
  int           ready_pct = 100;
  logic [N-1:0] force_off = '0;
  logic         rb_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int p, input byte unsigned b[$]);
    foreach (b[i]) begin
      drv_q[p].push_back(b[i]);
      mdl_q[p].push_back(b[i]);
    end
    flen_q[p].push_back(b.size());
  endtask

  // Frame length derived from the header rules: no-op 1, read 4, write 4+len.
  task automatic gen_frame(input int p);
    byte unsigned b[$];
    logic [7:0] hdr;
    int len;
    hdr = 8'($urandom);
    b.push_back(hdr);
    if (hdr[1:0] != 2'b00) begin
      len = $urandom_range(1, 12);
      b.push_back(8'($urandom));
      b.push_back(8'(len));
      b.push_back(8'h00);
      if (hdr[0]) for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    end
    push_frame(p, b);
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (drv_q[p].size() > 0 && !force_off[p] && $urandom_range(0, 99) < valid_pct) begin
        s_tvalid[p]       = 1'b1;
        s_tdata[p*8 +: 8] = drv_q[p][0];
      end else begin
        s_tvalid[p]       = 1'b0;
        s_tdata[p*8 +: 8] = 8'($urandom);
      end
    end
    m_tready = ($urandom_range(0, 99) < ready_pct);
    if (rb_rand) begin
      rb_tvalid   = 1'($urandom);
      rb_tlast    = 1'($urandom);
      rb_tdata    = 8'($urandom);
      rb_tdest    = 8'($urandom_range(0, 11));
      rb_m_tready = N'($urandom);
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_rdy, exp_rv, exp_rl;
    logic exp_v, exp_rr, found;
    int q;
    exp_rdy = '0;
    exp_v   = 1'b0;
    if (cur >= 0) begin
      exp_v        = s_tvalid[cur];
      exp_rdy[cur] = m_tready;
    end
    check("s_tready", s_tready, exp_rdy);
    check("m_tvalid", m_tvalid, exp_v);
    check("grant_active", grant_active, cur >= 0);
    if (cur >= 0) begin
      check("m_tid", m_tid, cur);
      if (exp_v && mdl_q[cur].size() > 0) check("m_tdata", m_tdata, mdl_q[cur][0]);
    end
    exp_rv = '0;
    exp_rl = '0;
    exp_rr = 1'b1;
    if (rb_tdest < N) begin
      exp_rv[rb_tdest] = rb_tvalid;
      exp_rl[rb_tdest] = rb_tlast;
      exp_rr           = rb_m_tready[rb_tdest];
    end
    check("rb_tvalid", rb_m_tvalid, exp_rv);
    check("rb_tlast", rb_m_tlast, exp_rl);
    check("rb_tready", rb_tready, exp_rr);
    check("rb_tdata", rb_m_tdata, {N{rb_tdata}});
    for (int p = 0; p < N; p++) begin
      if (s_tvalid[p] && s_tready[p]) begin
        acc_tid.push_back(int'(m_tid));
        acc_cyc.push_back(cyc);
        if (drv_q[p].size() > 0) void'(drv_q[p].pop_front());
      end
    end
    if (cur < 0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        q = (rr + i) % N;
        if (!found && s_tvalid[q]) begin
          found = 1'b1;
          cur = q;
          remaining = (flen_q[q].size() > 0) ? flen_q[q].pop_front() : 1;
        end
      end
    end else if (s_tvalid[cur] && m_tready) begin
      if (mdl_q[cur].size() > 0) void'(mdl_q[cur].pop_front());
      remaining--;
      if (remaining == 0) begin
        rr  = (cur + 1) % N;
        cur = -1;
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    drive();
    @(negedge aclk);
    check_cycle();
    cyc++;
  endtask

  function automatic bit pending();
    for (int p = 0; p < N; p++) if (drv_q[p].size() > 0) return 1'b1;
    return cur >= 0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout_%s actual=%0d cycles required=<%0d", name, n, budget);
    end
    step();
  endtask

  task automatic do_reset();
    aresetn     = 1'b0;
    s_tvalid    = '0;
    rb_tvalid   = 1'b0;
    rb_tdest    = '0;
    rb_m_tready = '0;
    for (int p = 0; p < N; p++) begin
      drv_q[p].delete();
      mdl_q[p].delete();
      flen_q[p].delete();
    end
    cur = -1;
    rr  = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", s_tready, '0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tid", m_tid, 8'h00);
    check("rst_grant_active", grant_active, 1'b0);
    check("rst_rb_tvalid", rb_m_tvalid, '0);
    aresetn = 1'b1;
    acc_tid.delete();
    acc_cyc.delete();
  endtask

  int exp_b[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3};
  int n_p0, n_p1, last_p, first_p3, n;

  initial begin
    // Port 2 write frame, then rr pointer sits at 3.
    do_reset();
    push_frame(2, '{8'h01, 8'h10, 8'h02, 8'h00, 8'hAA, 8'hBB});
    wait_idle("wr_p2", 100);
    check("wr_p2_count", acc_tid.size(), 6);
    n = 0;
    foreach (acc_tid[i]) if (acc_tid[i] == 2) n++;
    check("wr_p2_tid", n, 6);
    check("wr_p2_gactive_after", grant_active, 1'b0);
    push_frame(0, '{8'h02, 8'h20, 8'h01, 8'h00});
    push_frame(3, '{8'h02, 8'h30, 8'h01, 8'h00});
    wait_idle("rr_after_p2", 100);
    check("rr_ptr_is_3", (acc_tid.size() > 6) ? acc_tid[6] : -1, 3);

    // Simultaneous read frames from ports 0, 1, 3.
    do_reset();
    push_frame(0, '{8'h02, 8'h40, 8'h01, 8'h00});
    push_frame(1, '{8'h02, 8'h41, 8'h01, 8'h00});
    push_frame(3, '{8'h02, 8'h43, 8'h01, 8'h00});
    wait_idle("rd_three", 100);
    check("rd_three_count", acc_tid.size(), 12);
    for (int i = 0; i < 12; i++) if (i < acc_tid.size()) check("rd_three_order", acc_tid[i], exp_b[i]);
    if (acc_cyc.size() == 12) begin
      check("rd_gap_0_1", acc_cyc[4] - acc_cyc[3], 2);
      check("rd_gap_1_3", acc_cyc[8] - acc_cyc[7], 2);
      check("rd_frame_contig", acc_cyc[3] - acc_cyc[0], 3);
    end

    // No-op header from port 1.
    acc_tid.delete();
    push_frame(1, '{8'h00});
    wait_idle("noop", 50);
    check("noop_count", acc_tid.size(), 1);
    check("noop_tid", (acc_tid.size() > 0) ? acc_tid[0] : -1, 1);

    // Length 0x0000 write from port 0 holds grant for 65536 payload bytes.
    begin
      byte unsigned big[$];
      big = '{8'h01, 8'h50, 8'h00, 8'h00};
      for (int i = 0; i < 65536; i++) big.push_back(8'(i ^ (i >> 8)));
      acc_tid.delete();
      push_frame(0, big);
    end
    repeat (3) step();
    push_frame(3, '{8'h02, 8'h51, 8'h01, 8'h00});
    wait_idle("len0", 70000);
    n_p0 = 0;
    last_p = -1;
    first_p3 = -1;
    foreach (acc_tid[i]) begin
      if (acc_tid[i] == 0) begin n_p0++; last_p = i; end
      if (acc_tid[i] == 3 && first_p3 < 0) first_p3 = i;
    end
    check("len0_bytes", n_p0, 65540);
    check("len0_no_interleave", first_p3 > last_p, 1'b1);

    // Granted port stalls mid-payload while port 3 requests.
    acc_tid.delete();
    push_frame(1, '{8'h01, 8'h60, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    n = 0;
    while (acc_tid.size() < 6 && n < 200) begin step(); n++; end
    check("stall_reached_payload", acc_tid.size() >= 6, 1'b1);
    force_off[1] = 1'b1;
    push_frame(3, '{8'h02, 8'h61, 8'h01, 8'h00});
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_p3_blocked", s_tready[3], 1'b0);
      check("stall_grant_held", m_tid, 8'd1);
    end
    force_off[1] = 1'b0;
    wait_idle("stall", 200);
    n_p1 = 0;
    last_p = -1;
    first_p3 = -1;
    foreach (acc_tid[i]) begin
      if (acc_tid[i] == 1) begin n_p1++; last_p = i; end
      if (acc_tid[i] == 3 && first_p3 < 0) first_p3 = i;
    end
    check("stall_p1_bytes", n_p1, 12);
    check("stall_p3_after", first_p3 > last_p, 1'b1);

    // Randomized traffic with random backpressure and readback.
    valid_pct = 60;
    ready_pct = 70;
    rb_rand   = 1'b1;
    for (int p = 0; p < N; p++) for (int k = 0; k < 6; k++) gen_frame(p);
    wait_idle("random", 20000);
    rb_rand   = 1'b0;
    valid_pct = 100;
    ready_pct = 100;

    // Directed readback routing.
    rb_tdest    = 8'd1;
    rb_tvalid   = 1'b1;
    rb_m_tready = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      rb_tdata = 8'hC0 + 8'(k);
      rb_tlast = (k == 2);
      step();
      check("rb1_valid", rb_m_tvalid, 4'b0010);
      check("rb1_last", rb_m_tlast, (k == 2) ? 4'b0010 : 4'b0000);
      check("rb1_ready", rb_tready, 1'b1);
      check("rb1_data", rb_m_tdata[15:8], 8'hC0 + 8'(k));
    end
    rb_m_tready = 4'b1101;
    step();
    check("rb1_backpressure", rb_tready, 1'b0);
    rb_tdest    = 8'd9;
    rb_m_tready = 4'b0000;
    step();
    check("rb9_ready", rb_tready, 1'b1);
    check("rb9_valid", rb_m_tvalid, 4'b0000);
    rb_tvalid = 1'b0;
    step();
    check("rb_idle_valid", rb_m_tvalid, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
